// File: rtl/instr_loader_if.sv
// Byte-stream intake and instruction-memory store port of the program loader.
// master = loader side, slave = host/memory side.
interface instr_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              store_en;
  logic [ADDR_W-1:0] store_address;
  logic [31:0]       store_data;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, store_en, store_address, store_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, store_en, store_address, store_data
  );
endinterface

// File: rtl/instr_loader.sv
// Program loader: header byte N, then 4*N little-endian payload bytes written to imem words 0..N-1.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in state S_CHK.
module instr_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  instr_loader_if.master    bus,
  output logic              core_reset_n,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e FinState = S_CHK;
`else
  localparam state_e FinState = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [7:0]        nWords_q, nWords_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [23:0]       word_q, word_d;
  logic              storeEn_q, storeEn_d;
  logic [ADDR_W-1:0] storeAddr_q, storeAddr_d;
  logic [31:0]       storeData_q, storeData_d;
  logic              coreResetN_q, coreResetN_d;
  logic              loadDone_q, loadDone_d;
  logic              loadError_q, loadError_d;
  logic [ADDR_W:0]   wordsLoaded_q, wordsLoaded_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif
  logic              rxReady;
  logic              xfer;

  always_comb begin
    rxReady = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef LOADER_CHECKSUM_EN
              || (state_q == S_CHK)
`endif
              ;
  end

  assign xfer              = rxReady & bus.rx_valid;
  assign bus.rx_ready      = rxReady;
  assign bus.store_en      = storeEn_q;
  assign bus.store_address = storeAddr_q;
  assign bus.store_data    = storeData_q;
  assign core_reset_n      = coreResetN_q;
  assign load_done         = loadDone_q;
  assign load_error        = loadError_q;
  assign words_loaded      = wordsLoaded_q;

  always_comb begin
    state_d       = state_q;
    nWords_d      = nWords_q;
    byteIdx_d     = byteIdx_q;
    word_d        = word_q;
    storeEn_d     = 1'b0;
    storeAddr_d   = storeAddr_q;
    storeData_d   = storeData_q;
    coreResetN_d  = 1'b0;
    loadDone_d    = 1'b0;
    loadError_d   = 1'b0;
    wordsLoaded_d = wordsLoaded_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d         = xor_q;
`endif

    case (state_q)
      S_IDLE: ;
      S_HDR: begin
        if (xfer) begin
          nWords_d = bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
          xor_d = bus.rx_data;
`endif
          if (32'(bus.rx_data) > DEPTH) state_d = S_ERROR;
          else if (bus.rx_data == 8'd0) state_d = FinState;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          xor_d = xor_q ^ bus.rx_data;
`endif
          byteIdx_d = byteIdx_q + 2'd1;
          case (byteIdx_q)
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              // Top byte goes straight into the store register so the word is ready in WRITE.
              storeData_d = {bus.rx_data, word_q};
              storeAddr_d = wordsLoaded_q[ADDR_W-1:0];
              storeEn_d   = 1'b1;
              state_d     = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        wordsLoaded_d = wordsLoaded_q + 1'b1;
        if ((8'(wordsLoaded_q) + 8'd1) == nWords_q) state_d = FinState;
        else                                        state_d = S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (bus.rx_data == xor_q) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        loadDone_d   = 1'b1;
        coreResetN_d = 1'b1;
      end
      S_ERROR: loadError_d = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // A new session may only begin from a resting state; status flags drop on the same edge.
    if (load_start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR)) begin
      state_d       = S_HDR;
      wordsLoaded_d = '0;
      storeAddr_d   = '0;
      byteIdx_d     = 2'd0;
      loadDone_d    = 1'b0;
      coreResetN_d  = 1'b0;
      loadError_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_d         = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      nWords_q      <= 8'd0;
      byteIdx_q     <= 2'd0;
      word_q        <= 24'd0;
      storeEn_q     <= 1'b0;
      storeAddr_q   <= '0;
      storeData_q   <= 32'd0;
      coreResetN_q  <= 1'b0;
      loadDone_q    <= 1'b0;
      loadError_q   <= 1'b0;
      wordsLoaded_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      nWords_q      <= nWords_d;
      byteIdx_q     <= byteIdx_d;
      word_q        <= word_d;
      storeEn_q     <= storeEn_d;
      storeAddr_q   <= storeAddr_d;
      storeData_q   <= storeData_d;
      coreResetN_q  <= coreResetN_d;
      loadDone_q    <= loadDone_d;
      loadError_q   <= loadError_d;
      wordsLoaded_q <= wordsLoaded_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q         <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: directed sessions plus randomized images checked against a word-list model.
module tb_instr_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            load_start;
  logic            core_reset_n;
  logic            load_done;
  logic            load_error;
  logic [ADDR_W:0] words_loaded;

  instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .bus          (bus),
    .core_reset_n (core_reset_n),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          nChecks = 0;
  int          nFail   = 0;
  logic [31:0] txWords[$];
  int          wrAddr[$];
  logic [31:0] wrData[$];
  int          monErr  = 0;
  bit          prevEn  = 0;
  bit          badChk  = 0;

  // Memory-side observer: log every write, flag multi-cycle strobes or a byte accepted during a write.
  always @(negedge clk) begin
    if (bus.store_en === 1'b1) begin
      wrAddr.push_back(int'(bus.store_address));
      wrData.push_back(bus.store_data);
      if (prevEn || bus.rx_ready !== 1'b0) monErr++;
    end
    prevEn = (bus.store_en === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_rx_ready"},     64'(bus.rx_ready),      64'd0);
    check({tag, "_store_en"},     64'(bus.store_en),      64'd0);
    check({tag, "_store_addr"},   64'(bus.store_address), 64'd0);
    check({tag, "_store_data"},   64'(bus.store_data),    64'd0);
    check({tag, "_core_reset_n"}, 64'(core_reset_n),      64'd0);
    check({tag, "_load_done"},    64'(load_done),         64'd0);
    check({tag, "_load_error"},   64'(load_error),        64'd0);
    check({tag, "_words_loaded"}, 64'(words_loaded),      64'd0);
  endtask

  task automatic pulseStart();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit stall);
    bit acc;
    int guard;
    if (stall) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    acc   = 0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = (bus.rx_ready === 1'b1);
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("rx_accept_timeout", 64'd0, 64'd1);
  endtask

  // Builds the byte stream from the word list: header, little-endian payload, optional XOR trailer.
  task automatic applyStimulus(input logic [7:0] hdr, input bit stall, output int hdrCyc);
    logic [7:0] ck;
    logic [7:0] b;
    ck = hdr;
    wrAddr.delete();
    wrData.delete();
    monErr = 0;
    sendByte(hdr, stall);
    hdrCyc = cyc;
    if (int'(hdr) <= DEPTH) begin
      foreach (txWords[i]) begin
        for (int k = 0; k < 4; k++) begin
          b  = 8'(txWords[i] >> (8 * k));
          ck = ck ^ b;
          sendByte(b, stall);
        end
      end
`ifdef LOADER_CHECKSUM_EN
      sendByte(badChk ? (ck ^ 8'h01) : ck, stall);
`endif
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic waitEnd(input int hdrCyc, output int lat);
    int g;
    g = 0;
    while (g < 3000) begin
      @(negedge clk);
      if (load_done === 1'b1 || load_error === 1'b1) break;
      g++;
    end
    lat = cyc - hdrCyc;
    if (g >= 3000) check("end_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkOutput(input string tag, input int expLat, input int lat);
    int n;
    n = txWords.size();
    check({tag, "_nwrites"}, 64'(wrAddr.size()), 64'(n));
    for (int i = 0; i < n && i < wrAddr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(wrAddr[i]), 64'(i));
      check($sformatf("%s_data%0d", tag, i), 64'(wrData[i]), 64'(txWords[i]));
    end
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'(n));
    check({tag, "_load_done"},    64'(load_done),    64'd1);
    check({tag, "_core_reset_n"}, 64'(core_reset_n), 64'd1);
    check({tag, "_load_error"},   64'(load_error),   64'd0);
    check({tag, "_rx_ready"},     64'(bus.rx_ready), 64'd0);
    check({tag, "_monitor"},      64'(monErr),       64'd0);
    if (n > 0) begin
      check({tag, "_hold_data"}, 64'(bus.store_data),    64'(txWords[n-1]));
      check({tag, "_hold_addr"}, 64'(bus.store_address), 64'(n - 1));
    end
    if (expLat >= 0) check({tag, "_latency"}, 64'(lat), 64'(expLat));
  endtask

  initial begin
    int h;
    int lat;
    int n;
    int g;
    bit st;

    reset        = 1'b1;
    load_start   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 64'(bus.rx_ready), 64'd0);

    $display("[TB] basic load");
    txWords = '{32'h00100093, 32'h00200133};
    pulseStart();
    applyStimulus(8'd2, 0, h);
    waitEnd(h, lat);
    checkOutput("basic", 11 + CK, lat);

    $display("[TB] empty image restarted from DONE");
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    check("restart_core_reset_n", 64'(core_reset_n), 64'd0);
    check("restart_load_done",    64'(load_done),    64'd0);
    txWords.delete();
    applyStimulus(8'd0, 0, h);
    waitEnd(h, lat);
    checkOutput("empty", 1 + CK, lat);

    $display("[TB] oversize header");
    pulseStart();
    applyStimulus(8'h41, 0, h);
    waitEnd(h, lat);
    repeat (3) @(negedge clk);
    check("over_load_error",   64'(load_error),    64'd1);
    check("over_core_reset_n", 64'(core_reset_n),  64'd0);
    check("over_load_done",    64'(load_done),     64'd0);
    check("over_rx_ready",     64'(bus.rx_ready),  64'd0);
    check("over_nwrites",      64'(wrAddr.size()), 64'd0);
    pulseStart();
    check("over_clear_error", 64'(load_error), 64'd0);
    txWords = '{32'hDEADBEEF};
    applyStimulus(8'd1, 0, h);
    waitEnd(h, lat);
    checkOutput("recover", 6 + CK, lat);

    $display("[TB] stalled stream");
    txWords.delete();
    for (int i = 0; i < 4; i++) txWords.push_back($urandom);
    pulseStart();
    applyStimulus(8'd4, 1, h);
    waitEnd(h, lat);
    checkOutput("stall", -1, lat);

    $display("[TB] full depth");
    txWords.delete();
    for (int i = 0; i < DEPTH; i++) txWords.push_back(32'(i));
    pulseStart();
    applyStimulus(8'(DEPTH), 0, h);
    waitEnd(h, lat);
    checkOutput("full", 5 * DEPTH + 1 + CK, lat);

    $display("[TB] random images");
    for (int r = 0; r < 3; r++) begin
      n  = $urandom_range(1, 12);
      st = 1'($urandom_range(0, 1));
      txWords.delete();
      for (int i = 0; i < n; i++) txWords.push_back($urandom);
      pulseStart();
      applyStimulus(8'(n), st, h);
      waitEnd(h, lat);
      checkOutput($sformatf("rand%0d", r), st ? -1 : 5 * n + 1 + CK, lat);
    end

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    txWords = '{32'h11223344};
    pulseStart();
    applyStimulus(8'd1, 0, h);
    waitEnd(h, lat);
    checkOutput("chk_good", 7, lat);
    badChk = 1;
    pulseStart();
    applyStimulus(8'd1, 0, h);
    waitEnd(h, lat);
    repeat (2) @(negedge clk);
    badChk = 0;
    check("chk_bad_error",   64'(load_error),    64'd1);
    check("chk_bad_done",    64'(load_done),     64'd0);
    check("chk_bad_nwrites", 64'(wrAddr.size()), 64'd1);
    if (wrData.size() > 0) check("chk_bad_data0", 64'(wrData[0]), 64'h11223344);
`endif

    $display("[TB] mid-load reset");
    txWords.delete();
    for (int i = 0; i < DEPTH; i++) txWords.push_back(32'(i));
    pulseStart();
    wrAddr.delete();
    wrData.delete();
    sendByte(8'(DEPTH), 0);
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < 4; k++) sendByte(8'(txWords[i] >> (8 * k)), 0);
    g = 0;
    while (wrAddr.size() < 10 && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("mid_nwrites", 64'(wrAddr.size()), 64'd10);
    #1;
    reset = 1'b1;
    #1;
    checkReset("midreset");
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_core_reset_n", 64'(core_reset_n), 64'd0);
    check("post_reset_rx_ready",     64'(bus.rx_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
